// File: rtl/kmeans_pkg.sv
// Shared k-means widths and FSM state encoding.
// Also used by new_means_calculation_block.
package kmeans_pkg;

  localparam int unsigned CORD_W       = 13;
  localparam int unsigned ACC_CORD_W   = 22;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned DATA_W       = 91;
  localparam int unsigned ACC_W        = 154;
  localparam int unsigned NUM_CORD     = 7;
  localparam int unsigned CENTROID_NUM = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/cord_vec_adder.sv
// Seven parallel sign-extend-and-add lanes: packed point plus packed sum.
// Each lane wraps independently modulo 2^accum_cord_width.
module cord_vec_adder
  import kmeans_pkg::*;
#(
  parameter int unsigned dataWidth        = DATA_W,
  parameter int unsigned cordinate_width  = CORD_W,
  parameter int unsigned accum_cord_width = ACC_CORD_W,
  parameter int unsigned accum_width      = ACC_W
) (
  input  logic [dataWidth-1:0]   i_point,
  input  logic [accum_width-1:0] i_sum,
  output logic [accum_width-1:0] o_sum
);

  localparam int unsigned NumCord = accum_width / accum_cord_width;
  localparam int unsigned ExtW    = accum_cord_width - cordinate_width;

  for (genvar k = 0; k < NumCord; k++) begin : g_cord
    logic [accum_cord_width-1:0] w_ext;

    assign w_ext = {{ExtW{i_point[k*cordinate_width + cordinate_width - 1]}},
                    i_point[k*cordinate_width +: cordinate_width]};
    assign o_sum[k*accum_cord_width +: accum_cord_width] =
        i_sum[k*accum_cord_width +: accum_cord_width] + w_ext;
  end

endmodule

// File: rtl/centroid_accumulator.sv
// Per-centroid coordinate sums and point counts for one k-means iteration.
// Points pass through a one-stage input register, then commit to the selected accumulator.
module centroid_accumulator
  import kmeans_pkg::*;
#(
  parameter int unsigned dataWidth        = DATA_W,
  parameter int unsigned cordinate_width  = CORD_W,
  parameter int unsigned accum_cord_width = ACC_CORD_W,
  parameter int unsigned accum_width      = ACC_W,
  parameter int unsigned count_width      = CNT_W,
  parameter int unsigned centroid_num     = CENTROID_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accum_clear,
  input  logic                   point_valid,
  input  logic [dataWidth-1:0]   point_data,
  input  logic [2:0]             point_cent,
  input  logic                   point_last,
  output logic [accum_width-1:0] accum_1,
  output logic [accum_width-1:0] accum_2,
  output logic [accum_width-1:0] accum_3,
  output logic [accum_width-1:0] accum_4,
  output logic [accum_width-1:0] accum_5,
  output logic [accum_width-1:0] accum_6,
  output logic [accum_width-1:0] accum_7,
  output logic [accum_width-1:0] accum_8,
  output logic [count_width-1:0] cnt_1,
  output logic [count_width-1:0] cnt_2,
  output logic [count_width-1:0] cnt_3,
  output logic [count_width-1:0] cnt_4,
  output logic [count_width-1:0] cnt_5,
  output logic [count_width-1:0] cnt_6,
  output logic [count_width-1:0] cnt_7,
  output logic [count_width-1:0] cnt_8,
  output logic                   accum_ready,
  output logic                   cnt_ovf
);

  localparam logic [count_width-1:0] CntMax = '1;

  state_e r_state, w_state_next;

  logic                   r_pt_valid;
  logic [dataWidth-1:0]   r_pt_data;
  logic [2:0]             r_pt_cent;
  logic                   r_pt_last;

  logic [accum_width-1:0] r_accum [centroid_num];
  logic [count_width-1:0] r_cnt   [centroid_num];
  logic                   r_ovf;

  logic                   w_commit;
  logic                   w_sat;
  logic [accum_width-1:0] w_new_sum;

  assign w_commit = (r_state == StAccum) && r_pt_valid;
  assign w_sat    = (r_cnt[r_pt_cent] == CntMax);

  // The add reads the accumulator as of this cycle, which already holds any point
  // committed on the previous edge, so same-centroid back-to-back points are safe.
  cord_vec_adder #(
    .dataWidth        (dataWidth),
    .cordinate_width  (cordinate_width),
    .accum_cord_width (accum_cord_width),
    .accum_width      (accum_width)
  ) u_adder (
    .i_point (r_pt_data),
    .i_sum   (r_accum[r_pt_cent]),
    .o_sum   (w_new_sum)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (accum_clear) w_state_next = StAccum;
      StAccum: begin
        if (accum_clear) w_state_next = StAccum;
        else if (w_commit && r_pt_last) w_state_next = StHold;
      end
      StHold:  if (accum_clear) w_state_next = StAccum;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pt_valid <= 1'b0;
      r_pt_data  <= '0;
      r_pt_cent  <= '0;
      r_pt_last  <= 1'b0;
    end else if (accum_clear) begin
      r_pt_valid <= 1'b0;
      r_pt_data  <= '0;
      r_pt_cent  <= '0;
      r_pt_last  <= 1'b0;
    end else if ((r_state == StAccum) && point_valid) begin
      r_pt_valid <= 1'b1;
      r_pt_data  <= point_data;
      r_pt_cent  <= point_cent;
      r_pt_last  <= point_last;
    end else begin
      r_pt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < centroid_num; i++) begin
        r_accum[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_ovf <= 1'b0;
    end else if (accum_clear) begin
      for (int i = 0; i < centroid_num; i++) begin
        r_accum[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_commit) begin
      if (w_sat) begin
        r_ovf <= 1'b1;
      end else begin
        r_accum[r_pt_cent] <= w_new_sum;
        r_cnt[r_pt_cent]   <= r_cnt[r_pt_cent] + count_width'(1);
      end
    end
  end

  assign accum_1 = r_accum[0];
  assign accum_2 = r_accum[1];
  assign accum_3 = r_accum[2];
  assign accum_4 = r_accum[3];
  assign accum_5 = r_accum[4];
  assign accum_6 = r_accum[5];
  assign accum_7 = r_accum[6];
  assign accum_8 = r_accum[7];

  assign cnt_1 = r_cnt[0];
  assign cnt_2 = r_cnt[1];
  assign cnt_3 = r_cnt[2];
  assign cnt_4 = r_cnt[3];
  assign cnt_5 = r_cnt[4];
  assign cnt_6 = r_cnt[5];
  assign cnt_7 = r_cnt[6];
  assign cnt_8 = r_cnt[7];

  assign accum_ready = (r_state == StHold);
  assign cnt_ovf     = r_ovf;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Directed bench for centroid_accumulator with an integer reference model
// compared every cycle, plus literal spot checks.
module tb_centroid_accumulator;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         accum_clear = 1'b0;
  logic         point_valid = 1'b0;
  logic [90:0]  point_data = '0;
  logic [2:0]   point_cent = '0;
  logic         point_last = 1'b0;
  logic [153:0] accum_1, accum_2, accum_3, accum_4, accum_5, accum_6, accum_7, accum_8;
  logic [9:0]   cnt_1, cnt_2, cnt_3, cnt_4, cnt_5, cnt_6, cnt_7, cnt_8;
  logic         accum_ready, cnt_ovf;

  always #5 clk = ~clk;

  centroid_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .accum_clear (accum_clear),
    .point_valid (point_valid),
    .point_data  (point_data),
    .point_cent  (point_cent),
    .point_last  (point_last),
    .accum_1     (accum_1),
    .accum_2     (accum_2),
    .accum_3     (accum_3),
    .accum_4     (accum_4),
    .accum_5     (accum_5),
    .accum_6     (accum_6),
    .accum_7     (accum_7),
    .accum_8     (accum_8),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2),
    .cnt_3       (cnt_3),
    .cnt_4       (cnt_4),
    .cnt_5       (cnt_5),
    .cnt_6       (cnt_6),
    .cnt_7       (cnt_7),
    .cnt_8       (cnt_8),
    .accum_ready (accum_ready),
    .cnt_ovf     (cnt_ovf)
  );

  logic [153:0] d_acc [8];
  logic [9:0]   d_cnt [8];
  assign d_acc[0] = accum_1;  assign d_acc[1] = accum_2;
  assign d_acc[2] = accum_3;  assign d_acc[3] = accum_4;
  assign d_acc[4] = accum_5;  assign d_acc[5] = accum_6;
  assign d_acc[6] = accum_7;  assign d_acc[7] = accum_8;
  assign d_cnt[0] = cnt_1;    assign d_cnt[1] = cnt_2;
  assign d_cnt[2] = cnt_3;    assign d_cnt[3] = cnt_4;
  assign d_cnt[4] = cnt_5;    assign d_cnt[5] = cnt_6;
  assign d_cnt[6] = cnt_7;    assign d_cnt[7] = cnt_8;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain integer sums per centroid/coordinate.
  int          m_sum [8][7];
  int          m_cnt [8];
  bit          m_ovf = 1'b0;
  bit          m_coll = 1'b0;
  bit          m_ready = 1'b0;
  bit          p_v = 1'b0;
  bit          p_last = 1'b0;
  logic [90:0] p_data = '0;
  int          p_cent = 0;

  function automatic void m_zero();
    for (int c = 0; c < 8; c++) begin
      m_cnt[c] = 0;
      for (int k = 0; k < 7; k++) m_sum[c][k] = 0;
    end
    m_ovf   = 1'b0;
    m_ready = 1'b0;
    p_v     = 1'b0;
  endfunction

  function automatic logic [153:0] exp_acc(input int c);
    logic [153:0] r;
    logic [31:0]  t;
    r = '0;
    for (int k = 0; k < 7; k++) begin
      t = m_sum[c][k];
      r[22*k +: 22] = t[21:0];
    end
    return r;
  endfunction

  function automatic logic [90:0] pt(input int k, input int v);
    logic [90:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    r[13*k +: 13] = t[12:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [153:0] act, input logic [153:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    m_zero();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_zero();
        m_coll = 1'b0;
      end else if (accum_clear) begin
        m_zero();
        m_coll = 1'b1;
      end else begin
        automatic bit was = m_coll;
        if (p_v && was) begin
          if (m_cnt[p_cent] == 1023) begin
            m_ovf = 1'b1;
          end else begin
            m_cnt[p_cent]++;
            for (int k = 0; k < 7; k++)
              m_sum[p_cent][k] += int'($signed(p_data[13*k +: 13]));
          end
          if (p_last) begin
            m_coll  = 1'b0;
            m_ready = 1'b1;
          end
        end
        p_v = point_valid && was;
        if (p_v) begin
          p_data = point_data;
          p_cent = int'(point_cent);
          p_last = point_last;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("acc%0d", c + 1), d_acc[c], exp_acc(c));
        chk($sformatf("cnt%0d", c + 1), 154'(d_cnt[c]), 154'(m_cnt[c]));
      end
      chk("ready", 154'(accum_ready), 154'(m_ready));
      chk("ovf", 154'(cnt_ovf), 154'(m_ovf));
    end
  end

  task automatic drive(input bit clr, input bit v, input int cent, input logic [90:0] d,
                       input bit last);
    @(posedge clk);
    #2;
    accum_clear = clr;
    point_valid = v;
    point_cent  = cent[2:0];
    point_data  = d;
    point_last  = last;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_ready_lit", 154'(accum_ready), '0);
    chk("rst_cnt1_lit", 154'(cnt_1), '0);

    // Point while IDLE must be ignored.
    drive(1'b0, 1'b1, 0, pt(0, 4), 1'b0);
    idle();
    idle();
    chk("idle_cnt1_lit", 154'(cnt_1), '0);

    drive(1'b1, 1'b0, 0, '0, 1'b0);
    drive(1'b0, 1'b1, 0, pt(0, 7), 1'b0);
    idle();
    idle();
    chk("s1_acc1_lit", 154'(accum_1[21:0]), 154'(7));
    chk("s1_cnt1_lit", 154'(cnt_1), 154'(1));
    chk("s1_acc2_lit", accum_2, '0);

    drive(1'b0, 1'b1, 3, pt(2, -5), 1'b0);
    drive(1'b0, 1'b1, 3, pt(2, -5), 1'b0);
    drive(1'b0, 1'b1, 3, pt(2, 3), 1'b0);
    idle();
    idle();
    chk("s2_acc4_lit", 154'(accum_4[65:44]), 154'(22'h3FFFF9));
    chk("s2_cnt4_lit", 154'(cnt_4), 154'(3));

    drive(1'b0, 1'b1, 5, pt(6, 100), 1'b1);
    idle();
    chk("s3_ready_early_lit", 154'(accum_ready), '0);
    idle();
    chk("s3_ready_lit", 154'(accum_ready), 154'(1));
    drive(1'b0, 1'b1, 5, pt(6, 50), 1'b0);
    idle();
    idle();
    chk("s3_hold_cnt6_lit", 154'(cnt_6), 154'(1));
    chk("s3_hold_acc6_lit", 154'(accum_6[153:132]), 154'(100));

    drive(1'b1, 1'b0, 0, '0, 1'b0);
    repeat (1023) drive(1'b0, 1'b1, 1, pt(1, 1), 1'b0);
    drive(1'b0, 1'b1, 1, pt(1, 5), 1'b0);
    idle();
    idle();
    chk("s4_cnt2_lit", 154'(cnt_2), 154'(1023));
    chk("s4_acc2_lit", 154'(accum_2[43:22]), 154'(1023));
    chk("s4_ovf_lit", 154'(cnt_ovf), 154'(1));
    drive(1'b1, 1'b0, 0, '0, 1'b0);
    idle();
    chk("s4_ovf_clr_lit", 154'(cnt_ovf), '0);
    chk("s4_cnt2_clr_lit", 154'(cnt_2), '0);

    // Clear wins over a coincident point.
    drive(1'b1, 1'b1, 2, pt(0, 9), 1'b0);
    idle();
    idle();
    chk("s5_coinc_cnt3_lit", 154'(cnt_3), '0);
    // Point in flight when clear arrives is discarded.
    drive(1'b0, 1'b1, 4, pt(3, 11), 1'b0);
    drive(1'b1, 1'b0, 0, '0, 1'b0);
    idle();
    idle();
    chk("s5_flight_cnt5_lit", 154'(cnt_5), '0);
    chk("s5_flight_acc5_lit", accum_5, '0);

    drive(1'b0, 1'b1, 6, pt(4, -20), 1'b0);
    drive(1'b0, 1'b1, 6, pt(4, 8), 1'b0);
    idle();
    idle();
    chk("s5_pre_rst_cnt7_lit", 154'(cnt_7), 154'(2));
    @(posedge clk);
    #4 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b0, 1'b1, 0, pt(0, 3), 1'b0);
    idle();
    idle();
    chk("s5_rst_ready_lit", 154'(accum_ready), '0);
    chk("s5_rst_acc7_lit", accum_7, '0);
    for (int c = 0; c < 8; c++)
      chk($sformatf("s5_rst_cnt%0d_lit", c + 1), 154'(d_cnt[c]), '0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
